// File: rtl/data_memory.sv
// Word-organised data RAM for the load/store path: synchronous write,
// combinational read, synchronous clear, out-of-range accesses ignored/read as zero.
module data_memory #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             in_range;

  // Every bit above the index field must be zero; otherwise the access would alias.
  assign in_range = ((A >> (ADDR_LSB + IDX_W)) == '0);
  assign idx      = A[ADDR_LSB +: IDX_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (WE && in_range) begin
      mem[idx] <= WD;
    end
  end

  always_comb begin
    RD = '0;
    if (in_range) begin
      RD = mem[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed steps then randomized traffic
// compared against a word-array reference model.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;

  int passed;
  int total;

  logic [31:0] mdl [64];

  data_memory #(.DEPTH(64), .ADDR_LSB(2)) dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .RD    (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    logic [31:0] word;
    word = addr / 4;
    if (word < 64) return mdl[word];
    return 32'h0;
  endfunction

  task automatic ref_edge(input logic r, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
    logic [31:0] word;
    word = addr / 4;
    if (r) begin
      for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    end else if (we && word < 64) begin
      mdl[word] = wd;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    total++;
    assert (RD === exp) passed++;
    else $error("FAIL %s: A=%h RD=%h expected %h", tag, A, RD, exp);
  endtask

  // One clock: drive at negedge, check old value before the edge and new value after it.
  task automatic step(input string tag, input logic r, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    reset = r; WE = we; A = addr; WD = wd;
    #1 check({tag, "_pre"}, ref_read(addr));
    @(posedge clk);
    ref_edge(r, we, addr, wd);
    #1 check({tag, "_post"}, ref_read(addr));
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp);
    @(negedge clk);
    reset = 1'b0; WE = 1'b0; A = addr;
    #1 check(tag, exp);
  endtask

  initial begin
    logic [31:0] ra, rw;
    logic        rwe, rr;
    passed = 0;
    total  = 0;
    reset = 1'b0; WE = 1'b0; A = '0; WD = '0;
    for (int i = 0; i < 64; i++) mdl[i] = 32'h0;

    // Reset then read
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    ref_edge(1'b1, 1'b0, 32'h0, 32'h0);
    read_chk("rst_a0",  32'h0,  32'h0);
    read_chk("rst_a4",  32'h4,  32'h0);
    read_chk("rst_afc", 32'hFC, 32'h0);

    // Write then read back (same cycle after edge)
    step("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    read_chk("rd10", 32'h10, 32'hDEADBEEF);
    read_chk("rd14", 32'h14, 32'h0);

    // WE low leaves array unchanged
    step("we0", 1'b0, 1'b0, 32'h20, 32'h12345678);
    read_chk("rd20", 32'h20, 32'h0);

    // Alignment: low two address bits ignored
    step("wr8", 1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
    read_chk("rdB", 32'hB, 32'hCAFEF00D);
    read_chk("rd9", 32'h9, 32'hCAFEF00D);
    step("wrA", 1'b0, 1'b1, 32'hA, 32'h11111111);
    read_chk("rd8", 32'h8, 32'h11111111);

    // Range: index 64 and high-bit addresses must not alias into low words
    step("wr0", 1'b0, 1'b1, 32'h0, 32'h0BADF00D);
    step("wr100", 1'b0, 1'b1, 32'h100, 32'hFFFFFFFF);
    read_chk("rd100", 32'h100, 32'h0);
    read_chk("rd0_noalias", 32'h0, 32'h0BADF00D);
    step("wrhi", 1'b0, 1'b1, 32'h8000_0004, 32'h5A5A5A5A);
    read_chk("rd4_noalias", 32'h4, 32'h0);
    step("wrtop", 1'b0, 1'b1, 32'hFF, 32'h76543210);
    read_chk("rdFC", 32'hFC, 32'h76543210);

    // Reset priority over a write in the same cycle
    step("rstwr", 1'b1, 1'b1, 32'h10, 32'hAAAAAAAA);
    read_chk("rst_10", 32'h10, 32'h0);
    read_chk("rst_8",  32'h8,  32'h0);
    read_chk("rst_0",  32'h0,  32'h0);
    read_chk("rst_fc", 32'hFC, 32'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = $urandom();
        1:       ra = 32'h100 + $urandom_range(0, 7);
        default: ra = $urandom_range(0, 255);
      endcase
      rw  = $urandom();
      rwe = ($urandom_range(0, 2) != 0);
      rr  = ($urandom_range(0, 59) == 0);
      step("rnd", rr, rwe, ra, rw);
      if ((n % 25) == 0) begin
        for (int w = 0; w < 64; w++) read_chk("sweep", w * 4, mdl[w]);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
